// File: rtl/fetch.sv
// Instruction fetch unit: credit-limited word requests into an in-order,
// first-word-fall-through queue, with redirect flush and stale-response drop.
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_insn
);
    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic          run_q, run_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   buf_pc_q   [DEPTH];
    logic [31:0]   buf_pc_d   [DEPTH];
    logic [31:0]   buf_insn_q [DEPTH];
    logic [31:0]   buf_insn_d [DEPTH];

    logic          req_fire;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_pc_al;

    // Credit is counted on registered state only, so dec_ready never reaches imem_*.
    always_comb begin
        redirect_pc_al = redirect_pc & ~32'h3;
        imem_req_valid = run_q && !redirect && ((count_q + inflight_q) < DEPTH_C);
        imem_req_addr  = pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        dec_valid      = (count_q != '0);
        pop            = dec_valid && dec_ready;
        push           = imem_rsp_valid && (drop_q == '0) && !redirect;
        dec_pc         = dec_valid ? buf_pc_q[rd_ptr_q]   : 32'h0;
        dec_insn       = dec_valid ? buf_insn_q[rd_ptr_q] : 32'h0;
    end

    always_comb begin
        run_d      = 1'b1;
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_d     = drop_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        buf_pc_d   = buf_pc_q;
        buf_insn_d = buf_insn_q;

        inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
        count_d    = count_q + CW'(push) - CW'(pop);

        if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end
        if (imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
        if (push) begin
            buf_pc_d[wr_ptr_q]   = rsp_pc_q;
            buf_insn_d[wr_ptr_q] = imem_rsp_data;
            wr_ptr_d             = wr_ptr_q + PW'(1);
            rsp_pc_d             = rsp_pc_q + 32'd4;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // Everything still outstanding after this cycle belongs to the old path.
        if (redirect) begin
            pc_d     = redirect_pc_al;
            rsp_pc_d = redirect_pc_al;
            drop_d   = inflight_q - CW'(imem_rsp_valid);
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_q      <= 1'b0;
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            run_q      <= run_d;
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_pc_q   <= buf_pc_d;
        buf_insn_q <= buf_insn_d;
    end

    assert property (@(posedge clk) disable iff (!resetn)
                     !(push && !pop && (count_q == DEPTH_C)));

endmodule
